// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer owning the NZCV flag register.
// Optional feature macro: DMEM_TIMEOUT_EN (data-memory ack timeout with sticky err and ERR state).
module instr_sequencer #(
    parameter logic [3:0] FLAG_RESET     = 4'b0000,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    output logic [31:0] ir,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  flags,
    output logic        alu_en,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        reg_we,
    output logic        pc_inc,
    output logic [2:0]  state,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
`ifdef DMEM_TIMEOUT_EN
        WB     = 3'd5,
        ERR    = 3'd6
`else
        WB     = 3'd5
`endif
    } state_t;

    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_LOAD  = 4'b1101;
    localparam logic [3:0] OP_STORE = 4'b1110;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] ir_r;
    logic [3:0]  flags_r;
    logic        pc_inc_s;
    logic [3:0]  opcode_s;
    logic        set_flags_s;

    assign opcode_s    = ir_r[27:24];
    assign set_flags_s = ir_r[23];

    // Condition field evaluated against {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Logical ops only touch N,Z; CMP always writes all four
    function automatic logic [3:0] next_flags(input logic [3:0] op, input logic s,
                                              input logic [3:0] cur, input logic [3:0] alu);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h8, 4'h9, 4'hA: next_flags = s ? alu : cur;
            4'h3, 4'h4, 4'h5:                   next_flags = s ? {alu[3:2], cur[1:0]} : cur;
            4'hB:                               next_flags = alu;
            default:                            next_flags = cur;
        endcase
    endfunction

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_r;
    logic       err_r;
    logic       timeout_s;

    assign timeout_s = (state_r == MEM) && !dmem_ack && (wait_cnt_r == WAIT_LIMIT);
`endif

    // Next-state and transition-qualified pc advance
    always_comb begin
        state_s  = state_r;
        pc_inc_s = 1'b0;
        case (state_r)
            IDLE: begin
                state_s = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    state_s = DECODE;
                end else begin
                    state_s = FETCH;
                end
            end
            DECODE: begin
                if (!cond_pass(ir_r[31:28], flags_r) || (opcode_s == OP_NOP)) begin
                    pc_inc_s = 1'b1;
                    state_s  = FETCH;
                end else begin
                    state_s = EXEC;
                end
            end
            EXEC: begin
                if (opcode_s == OP_CMP) begin
                    pc_inc_s = 1'b1;
                    state_s  = FETCH;
                end else if ((opcode_s == OP_LOAD) || (opcode_s == OP_STORE)) begin
                    state_s = MEM;
                end else begin
                    state_s = WB;
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    if (opcode_s == OP_STORE) begin
                        pc_inc_s = 1'b1;
                        state_s  = FETCH;
                    end else begin
                        state_s = WB;
                    end
`ifdef DMEM_TIMEOUT_EN
                end else if (timeout_s) begin
                    state_s = ERR;
`endif
                end else begin
                    state_s = MEM;
                end
            end
            WB: begin
                pc_inc_s = 1'b1;
                state_s  = FETCH;
            end
`ifdef DMEM_TIMEOUT_EN
            ERR: begin
                state_s = ERR;
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, instruction register and NZCV flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ir_r    <= 32'h0000_0000;
            flags_r <= FLAG_RESET;
        end else begin
            state_r <= state_s;
            if ((state_r == FETCH) && imem_ack) begin
                ir_r <= instr;
            end
            if (state_r == EXEC) begin
                flags_r <= next_flags(opcode_s, set_flags_s, flags_r, alu_flags);
            end
        end
    end

`ifdef DMEM_TIMEOUT_EN
    // MEM wait counter, cleared whenever outside MEM; sticky timeout error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 8'd0;
            err_r      <= 1'b0;
        end else begin
            if (state_r != MEM) begin
                wait_cnt_r <= 8'd0;
            end else if (!dmem_ack) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign state    = state_r;
    assign ir       = ir_r;
    assign flags    = flags_r;
    assign imem_req = (state_r == FETCH);
    assign alu_en   = (state_r == EXEC);
    assign dmem_req = (state_r == MEM);
    assign dmem_we  = (state_r == MEM) && (opcode_s == OP_STORE);
    assign reg_we   = (state_r == WB);
    assign pc_inc   = pc_inc_s;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle state/strobe checks with hand-computed values.
// Build with DMEM_TIMEOUT_EN defined to exercise the timeout path.
module tb_instr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] instr;
    logic [31:0] ir;
    logic [3:0]  alu_flags;
    logic [3:0]  flags;
    logic        alu_en;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        reg_we;
    logic        pc_inc;
    logic [2:0]  state;
    logic        err;

    int checks;
    int failures;

    instr_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .instr     (instr),
        .ir        (ir),
        .alu_flags (alu_flags),
        .flags     (flags),
        .alu_en    (alu_en),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .reg_we    (reg_we),
        .pc_inc    (pc_inc),
        .state     (state),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // strobes = {imem_req, alu_en, dmem_req, dmem_we, reg_we, pc_inc}
    task automatic cyc(input string tag, input logic [2:0] exp_state, input logic [5:0] exp_strb);
        #1;
        chk({tag, "_state"}, {29'd0, state}, {29'd0, exp_state});
        chk({tag, "_strb"}, {26'd0, imem_req, alu_en, dmem_req, dmem_we, reg_we, pc_inc},
            {26'd0, exp_strb});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        imem_ack  = 1'b1;
        instr     = 32'hE000_0000;
        alu_flags = 4'b0000;
        dmem_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        cyc("rst", 3'd0, 6'b000000);
        chk("rst_ir", ir, 32'h0000_0000);
        chk("rst_flags", {28'd0, flags}, 32'h0);
        chk("rst_err", {31'd0, err}, 32'h0);

        // AL ADD S=0: 0,1,2,3,5,1
        rst_n = 1'b1;
        cyc("t1_idle", 3'd0, 6'b000000);
        tick(); cyc("t1_fetch", 3'd1, 6'b100000);
        tick(); cyc("t1_dec", 3'd2, 6'b000000);
        chk("t1_ir", ir, 32'hE000_0000);
        tick(); cyc("t1_exec", 3'd3, 6'b010000);
        tick(); cyc("t1_wb", 3'd5, 6'b000011);
        tick();
        instr = 32'hEB00_0000; alu_flags = 4'b0110;
        cyc("t1_fetch2", 3'd1, 6'b100000);
        chk("t1_flags", {28'd0, flags}, 32'h0);

        // CMP loads flags 0110, no writeback
        tick(); cyc("t2_cmp_dec", 3'd2, 6'b000000);
        tick(); cyc("t2_cmp_exec", 3'd3, 6'b010001);
        tick();
        instr = 32'h0000_0000; alu_flags = 4'b1111;
        cyc("t2_fetch", 3'd1, 6'b100000);
        chk("t2_flags_cmp", {28'd0, flags}, 32'h6);
        // EQ ADD executes (Z=1), S=0 so flags held
        tick(); cyc("t2_eq_dec", 3'd2, 6'b000000);
        tick(); cyc("t2_eq_exec", 3'd3, 6'b010000);
        tick(); cyc("t2_eq_wb", 3'd5, 6'b000011);
        chk("t2_flags_held", {28'd0, flags}, 32'h6);
        tick();
        instr = 32'h1000_0000;
        cyc("t2_fetch2", 3'd1, 6'b100000);
        // NE false: skip straight from DECODE
        tick(); cyc("t2_ne_dec", 3'd2, 6'b000001);
        tick();
        instr = 32'hEB00_0000; alu_flags = 4'b1111;
        cyc("t2_ne_fetch", 3'd1, 6'b100000);

        // flags=1111, then ORR S=1 with alu 0100 -> 0111
        tick(); tick(); cyc("t3_cmp_exec", 3'd3, 6'b010001);
        tick();
        instr = 32'hE380_0000; alu_flags = 4'b0100;
        cyc("t3_fetch", 3'd1, 6'b100000);
        chk("t3_flags_ones", {28'd0, flags}, 32'hF);
        tick(); tick(); cyc("t3_orr_exec", 3'd3, 6'b010000);
        tick(); cyc("t3_orr_wb", 3'd5, 6'b000011);
        chk("t3_flags_nz", {28'd0, flags}, 32'h7);
        tick();
        // GE with N=0,V=1 is false
        instr = 32'hA000_0000;
        tick(); cyc("t3_ge_dec", 3'd2, 6'b000001);
        tick();
        // AL NOP skipped
        instr = 32'hEF00_0000;
        tick(); cyc("t3_nop_dec", 3'd2, 6'b000001);
        tick();
        // ADD S=1 writes all flags
        instr = 32'hE080_0000; alu_flags = 4'b1001;
        tick(); tick(); tick(); cyc("t3_add_wb", 3'd5, 6'b000011);
        chk("t3_flags_add", {28'd0, flags}, 32'h9);
        tick();

        // Load, ack in 4th MEM cycle; instr changes ignored outside FETCH
        instr = 32'hED00_0000; alu_flags = 4'b0000;
        cyc("t4_fetch", 3'd1, 6'b100000);
        tick(); cyc("t4_dec", 3'd2, 6'b000000);
        instr = 32'h1234_5678;
        tick(); cyc("t4_exec", 3'd3, 6'b010000);
        tick(); cyc("t4_mem1", 3'd4, 6'b001000);
        tick(); cyc("t4_mem2", 3'd4, 6'b001000);
        tick(); cyc("t4_mem3", 3'd4, 6'b001000);
        tick(); dmem_ack = 1'b1;
        cyc("t4_mem4", 3'd4, 6'b001000);
        tick(); dmem_ack = 1'b0;
        cyc("t4_wb", 3'd5, 6'b000011);
        chk("t4_ir_held", ir, 32'hED00_0000);
        chk("t4_flags_held", {28'd0, flags}, 32'h9);
        tick();

        // Store: dmem_we during MEM, pc_inc on the ack cycle, no WB
        instr = 32'hEE00_0000;
        tick(); tick();
        dmem_ack = 1'b1;
        cyc("t5_exec_stray_ack", 3'd3, 6'b010000);
        dmem_ack = 1'b0;
        tick(); cyc("t5_mem1", 3'd4, 6'b001100);
        tick(); dmem_ack = 1'b1;
        cyc("t5_mem2", 3'd4, 6'b001101);
        tick(); dmem_ack = 1'b0;
        cyc("t5_fetch", 3'd1, 6'b100000);
        // Second store, reset while in MEM
        tick(); tick(); tick();
        cyc("t5_mem_pre_rst", 3'd4, 6'b001100);
        rst_n = 1'b0;
        cyc("t5_rst_mid", 3'd0, 6'b000000);
        chk("t5_rst_flags", {28'd0, flags}, 32'h0);
        chk("t5_rst_ir", ir, 32'h0000_0000);
        tick();
        instr = 32'hED00_0000;
        rst_n = 1'b1;
        tick(); cyc("t6_fetch", 3'd1, 6'b100000);
        tick(); tick(); tick();
`ifdef DMEM_TIMEOUT_EN
        // No ack: ERR after 16 MEM cycles, held until reset
        for (int i = 1; i < 16; i++) begin
            tick();
        end
        cyc("t6_mem16", 3'd4, 6'b001000);
        chk("t6_err_pre", {31'd0, err}, 32'h0);
        tick(); cyc("t6_err", 3'd6, 6'b000000);
        chk("t6_err_set", {31'd0, err}, 32'h1);
        dmem_ack = 1'b1;
        tick(); tick(); cyc("t6_err_hold", 3'd6, 6'b000000);
        chk("t6_err_sticky", {31'd0, err}, 32'h1);
        dmem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_err_rst", {31'd0, err}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        // Ack in the limit cycle wins
        for (int i = 1; i < 16; i++) begin
            tick();
        end
        dmem_ack = 1'b1;
        cyc("t6_ack16", 3'd4, 6'b001000);
        tick(); dmem_ack = 1'b0;
        cyc("t6_ack_wb", 3'd5, 6'b000011);
        chk("t6_ack_err", {31'd0, err}, 32'h0);
`else
        // Without the timeout MEM waits indefinitely
        for (int i = 1; i < 25; i++) begin
            tick();
        end
        cyc("t6_mem_wait", 3'd4, 6'b001000);
        chk("t6_err_tied", {31'd0, err}, 32'h0);
        tick(); dmem_ack = 1'b1;
        cyc("t6_mem_ack", 3'd4, 6'b001000);
        tick(); dmem_ack = 1'b0;
        cyc("t6_wb", 3'd5, 6'b000011);
`endif
        tick(); cyc("t6_fetch_end", 3'd1, 6'b100000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
